// File: rtl/ram_requester.sv
// ram_requester: cpu_ram_if initiator; fetch (if_*) and load/store (d_*) ports in, registered RAM request (ram_*) out, load data/done/err back
module ram_requester #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [BIT_WIDTH-1:0] if_addr,
  output logic [BIT_WIDTH-1:0] if_rdata,
  output logic                 if_done,
  output logic                 if_err,
  input  logic                 d_ren,
  input  logic                 d_wen,
  input  logic [BIT_WIDTH-1:0] d_addr,
  input  logic [2:0]           d_width,
  input  logic [BIT_WIDTH-1:0] d_wdata,
  output logic [BIT_WIDTH-1:0] d_rdata,
  output logic                 d_done,
  output logic                 d_err,
  output logic                 ram_ren,
  output logic                 ram_wen,
  output logic [BIT_WIDTH-1:0] ram_addr,
  output logic [1:0]           ram_width,
  output logic [BIT_WIDTH-1:0] ram_store,
  input  logic [BIT_WIDTH-1:0] ram_load,
  input  logic [1:0]           ram_state
);
  localparam logic [1:0] RAM_DATA = 2'd2, RAM_ERROR = 2'd3;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic own_d, own_d_n;
  logic [2:0] dw, dw_n;
  logic [7:0] cnt, cnt_n;
  logic ren_n, wen_n, if_done_n, if_err_n, d_done_n, d_err_n;
  logic [1:0] width_n;
  logic [BIT_WIDTH-1:0] addr_n, store_n, if_rdata_n, d_rdata_n, ext;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  logic d_req, d_bad, if_bad, got;
  assign d_req = d_ren | d_wen;
  assign d_bad = (d_ren & d_wen) | (d_width[1:0] == 2'b11) | (d_width[1:0] == 2'b01 & d_addr[0]) |
                 (d_width[1:0] == 2'b10 & |d_addr[1:0]);
  assign if_bad = |if_addr[1:0];
  assign got = ram_state == RAM_DATA;
  assign lane_b = 8'(ram_load >> {ram_addr[1:0], 3'b000});
  assign lane_h = 16'(ram_load >> {ram_addr[1], 4'b0000});
  assign ext = dw[1:0] == 2'b00 ? {{(BIT_WIDTH-8){!dw[2] && lane_b[7]}}, lane_b} :
               dw[1:0] == 2'b01 ? {{(BIT_WIDTH-16){!dw[2] && lane_h[15]}}, lane_h} : ram_load;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      own_d <= 1'b0;
      dw <= '0;
      cnt <= '0;
      ram_ren <= 1'b0;
      ram_wen <= 1'b0;
      ram_addr <= '0;
      ram_width <= '0;
      ram_store <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
      if_done <= 1'b0;
      if_err <= 1'b0;
      d_done <= 1'b0;
      d_err <= 1'b0;
    end else begin
      state <= state_n;
      own_d <= own_d_n;
      dw <= dw_n;
      cnt <= cnt_n;
      ram_ren <= ren_n;
      ram_wen <= wen_n;
      ram_addr <= addr_n;
      ram_width <= width_n;
      ram_store <= store_n;
      if_rdata <= if_rdata_n;
      d_rdata <= d_rdata_n;
      if_done <= if_done_n;
      if_err <= if_err_n;
      d_done <= d_done_n;
      d_err <= d_err_n;
    end
  end
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = (d_req || if_req) ? ((d_req ? d_bad : if_bad) ? RESP : BUSY) : IDLE;
    else if (state == BUSY)
      state_n = (got || ram_state == RAM_ERROR || cnt == 8'(TIMEOUT-1)) ? RESP : BUSY;
    else
      state_n = IDLE;
  end
  always_comb begin
    ren_n = ram_ren;
    wen_n = ram_wen;
    addr_n = ram_addr;
    width_n = ram_width;
    store_n = ram_store;
    if_rdata_n = if_rdata;
    d_rdata_n = d_rdata;
    own_d_n = own_d;
    dw_n = dw;
    cnt_n = cnt;
    if_done_n = 1'b0;
    if_err_n = 1'b0;
    d_done_n = 1'b0;
    d_err_n = 1'b0;
    if (state == IDLE && d_req) begin
      own_d_n = 1'b1;
      d_err_n = d_bad;
      if (!d_bad) begin
        ren_n = d_ren;
        wen_n = d_wen;
        addr_n = d_addr;
        width_n = d_width[1:0];
        dw_n = d_width;
        store_n = d_width[1:0] == 2'b00 ? {(BIT_WIDTH/8){d_wdata[7:0]}} :
                  d_width[1:0] == 2'b01 ? {(BIT_WIDTH/16){d_wdata[15:0]}} : d_wdata;
      end
    end else if (state == IDLE && if_req) begin
      own_d_n = 1'b0;
      if_err_n = if_bad;
      if (!if_bad) begin
        ren_n = 1'b1;
        addr_n = if_addr;
        width_n = 2'b10;
      end
    end else if (state == BUSY) begin
      cnt_n = cnt + 8'd1;
      if (state_n == RESP) begin
        ren_n = 1'b0;
        wen_n = 1'b0;
        d_done_n = own_d && got;
        d_err_n = own_d && !got;
        if_done_n = !own_d && got;
        if_err_n = !own_d && !got;
        if (got && ram_ren && own_d) d_rdata_n = ext;
        if (got && ram_ren && !own_d) if_rdata_n = ram_load;
      end
    end else if (state == RESP) begin
      cnt_n = '0;
    end
  end
endmodule

// File: tb/tb_ram_requester.sv
// tb_ram_requester: scoreboard bench for ram_requester against a latency-configurable RAM responder model
module tb_ram_requester;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic if_req = 1'b0, d_ren = 1'b0, d_wen = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [2:0] d_width = '0;
  logic [31:0] if_rdata, d_rdata, ram_addr, ram_store, ram_load;
  logic if_done, if_err, d_done, d_err, ram_ren, ram_wen;
  logic [1:0] ram_width, ram_state;
  ram_requester #(.BIT_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_err(if_err), .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr),
    .d_width(d_width), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_width(ram_width),
    .ram_store(ram_store), .ram_load(ram_load), .ram_state(ram_state)
  );
  localparam logic [1:0] RAM_FREE = 2'd0, RAM_ADDR = 2'd1, RAM_DATA = 2'd2, RAM_ERROR = 2'd3;
  logic [1:0] rs;
  logic [7:0] rc;
  logic [31:0] rload;
  logic [31:0] mem [0:255];
  logic [3:0] be;
  logic fire, en;
  int lat = 0;
  bit hold = 1'b0, force_err = 1'b0;
  int en_cnt = 0;
  int checks = 0, failures = 0;
  logic [31:0] exp_q [$];
  assign ram_state = rs;
  assign ram_load = rload;
  assign en = ram_ren | ram_wen;
  assign be = ram_width == 2'b00 ? 4'b0001 << ram_addr[1:0] : ram_width == 2'b01 ? 4'b0011 << ram_addr[1:0] : 4'hf;
  assign fire = !rst && en && !force_err && !hold && ((rs == RAM_FREE && lat == 0) || (rs == RAM_ADDR && rc == 0));
  always @(posedge clk) begin
    if (en) en_cnt <= en_cnt + 1;
    if (rst) begin
      rs <= RAM_FREE;
      rc <= '0;
      rload <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC000_0000 | i;
      mem[64] <= 32'h80FF_1234;
    end else begin
      if (fire) begin
        rload <= mem[ram_addr[9:2]];
        if (ram_wen)
          for (int b = 0; b < 4; b++)
            if (be[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_store[8*b +: 8];
      end
      case (rs)
        RAM_FREE:
          if (en) begin
            if (force_err) rs <= RAM_ERROR;
            else if (fire) rs <= RAM_DATA;
            else begin
              rs <= RAM_ADDR;
              rc <= lat > 0 ? 8'(lat - 1) : 8'd0;
            end
          end
        RAM_ADDR:
          if (!en) rs <= RAM_FREE;
          else if (fire) rs <= RAM_DATA;
          else if (rc != 0) rc <= rc - 8'd1;
        default: rs <= RAM_FREE;
      endcase
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_d(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(d_done || d_err) && n < 60);
  endtask
  task automatic wait_if(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(if_done || if_err) && n < 60);
  endtask
  task automatic data_op(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [2:0] w, input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
    int n, e0;
    if (rd && !wr && !exp_err) exp_q.push_back(exp_rd);
    e0 = en_cnt;
    d_ren = rd;
    d_wen = wr;
    d_addr = a;
    d_width = w;
    d_wdata = wd;
    wait_d(n);
    d_ren = 1'b0;
    d_wen = 1'b0;
    check({tag, "_err"}, 32'(d_err), 32'(exp_err));
    check({tag, "_done"}, 32'(d_done), 32'(!exp_err));
    if (d_done && rd && !wr && exp_q.size() > 0) check(tag, d_rdata, exp_q.pop_front());
    if (exp_err && !force_err) check({tag, "_noaccess"}, 32'(en_cnt - e0), 0);
    tick();
  endtask
  task automatic store_op(input string tag, input logic [31:0] a, input logic [2:0] w,
                          input logic [31:0] wd, input logic [31:0] exp_store);
    int n;
    d_wen = 1'b1;
    d_addr = a;
    d_width = w;
    d_wdata = wd;
    tick();
    check({tag, "_wen"}, 32'(ram_wen), 1);
    check({tag, "_store"}, ram_store, exp_store);
    check({tag, "_width"}, 32'(ram_width), 32'(w[1:0]));
    wait_d(n);
    d_wen = 1'b0;
    check({tag, "_done"}, 32'(d_done), 1);
    tick();
  endtask
  initial begin
    int n, e0, k, pulses;
    logic ren16;
    repeat (3) tick();
    check("rst_ctl", 32'({ram_ren, ram_wen, if_done, if_err, d_done, d_err}), 0);
    check("rst_addr", ram_addr, 0);
    check("rst_store", ram_store, 0);
    check("rst_width", 32'(ram_width), 0);
    rst = 1'b0;
    d_ren = 1'b1;
    d_addr = 32'h100;
    d_width = 3'b010;
    exp_q.push_back(32'h80FF_1234);
    tick();
    check("t1_c1_ren", 32'(ram_ren), 1);
    check("t1_c1_addr", ram_addr, 32'h100);
    check("t1_c1_width", 32'(ram_width), 2);
    tick();
    check("t1_c2_ren", 32'(ram_ren), 1);
    check("t1_c2_done", 32'(d_done), 0);
    tick();
    check("t1_c3_done", 32'(d_done), 1);
    check("t1_c3_ren", 32'(ram_ren), 0);
    check("t1_rdata", d_rdata, exp_q.pop_front());
    d_ren = 1'b0;
    tick();
    lat = 1;
    data_op("lb", 1, 0, 32'h103, 3'b000, 0, 0, 32'hFFFF_FF80);
    data_op("lbu", 1, 0, 32'h103, 3'b100, 0, 0, 32'h0000_0080);
    data_op("lh", 1, 0, 32'h102, 3'b001, 0, 0, 32'hFFFF_80FF);
    data_op("lhu", 1, 0, 32'h102, 3'b101, 0, 0, 32'h0000_80FF);
    data_op("lb0", 1, 0, 32'h100, 3'b000, 0, 0, 32'h0000_0034);
    lat = 2;
    data_op("lw_lat2", 1, 0, 32'h104, 3'b010, 0, 0, 32'hC000_0041);
    lat = 0;
    store_op("sh", 32'h202, 3'b001, 32'h0000_ABCD, 32'hABCD_ABCD);
    data_op("lw_sh", 1, 0, 32'h200, 3'b010, 0, 0, 32'hABCD_0080);
    store_op("sb", 32'h201, 3'b000, 32'h0000_005A, 32'h5A5A_5A5A);
    data_op("lw_sb", 1, 0, 32'h200, 3'b010, 0, 0, 32'hABCD_5A80);
    check("st_keeps_rdata", d_rdata, 32'hABCD_5A80);
    if_req = 1'b1;
    if_addr = 32'h104;
    d_ren = 1'b1;
    d_addr = 32'h108;
    d_width = 3'b010;
    exp_q.push_back(32'hC000_0042);
    exp_q.push_back(32'hC000_0041);
    tick();
    check("arb_data_first", ram_addr, 32'h108);
    wait_d(n);
    check("arb_d_done", 32'(d_done), 1);
    check("arb_d_rdata", d_rdata, exp_q.pop_front());
    check("arb_no_if", 32'(if_done), 0);
    d_ren = 1'b0;
    tick();
    check("arb_gap", 32'(ram_ren), 0);
    tick();
    check("arb_if_ren", 32'(ram_ren), 1);
    check("arb_if_addr", ram_addr, 32'h104);
    check("arb_if_width", 32'(ram_width), 2);
    wait_if(n);
    if_req = 1'b0;
    check("arb_if_done", 32'(if_done), 1);
    check("arb_if_rdata", if_rdata, exp_q.pop_front());
    tick();
    data_op("misalign_w", 1, 0, 32'h101, 3'b010, 0, 1, 0);
    data_op("rw_both", 1, 1, 32'h100, 3'b010, 0, 1, 0);
    data_op("illegal_w", 1, 0, 32'h100, 3'b011, 0, 1, 0);
    data_op("half_odd", 1, 0, 32'h101, 3'b001, 0, 1, 0);
    e0 = en_cnt;
    if_req = 1'b1;
    if_addr = 32'h2;
    wait_if(n);
    if_req = 1'b0;
    check("if_misalign_err", 32'(if_err), 1);
    check("if_misalign_done", 32'(if_done), 0);
    check("if_misalign_noaccess", 32'(en_cnt - e0), 0);
    tick();
    force_err = 1'b1;
    data_op("ram_error", 1, 0, 32'h100, 3'b010, 0, 1, 0);
    force_err = 1'b0;
    hold = 1'b1;
    d_ren = 1'b1;
    d_addr = 32'h100;
    d_width = 3'b010;
    ren16 = 1'b0;
    for (k = 1; k <= 40; k++) begin
      tick();
      if (k == 16) ren16 = ram_ren;
      if (d_err || d_done) break;
    end
    check("to_cycle", 32'(k), 17);
    check("to_err", 32'(d_err), 1);
    check("to_ren16", 32'(ren16), 1);
    check("to_ren17", 32'(ram_ren), 0);
    d_ren = 1'b0;
    hold = 1'b0;
    tick();
    hold = 1'b1;
    d_ren = 1'b1;
    d_addr = 32'h104;
    repeat (3) tick();
    check("rst_mid_busy", 32'(ram_ren), 1);
    rst = 1'b1;
    tick();
    d_ren = 1'b0;
    hold = 1'b0;
    check("rst_mid_ctl", 32'({ram_ren, ram_wen, if_done, if_err, d_done, d_err}), 0);
    check("rst_mid_addr", ram_addr, 0);
    check("rst_mid_drdata", d_rdata, 0);
    check("rst_mid_ifrdata", if_rdata, 0);
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      tick();
      pulses += int'(d_done) + int'(d_err) + int'(ram_ren);
    end
    check("rst_no_pulse", 32'(pulses), 0);
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
